// File: rtl/raifes_qspi_arbiter.sv
// raifes_qspi_arbiter: serialises imem/dmem AHB-Lite masters onto one QSPI port with a watchdog; define RAIFES_QSPI_ARB_RR_EN for round-robin tie-break
module raifes_qspi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          DPRIO          = 1'b1
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [31:0] imem_haddr,
  input  logic        imem_hwrite,
  input  logic [2:0]  imem_hsize,
  input  logic [1:0]  imem_htrans,
  input  logic [31:0] imem_hwdata,
  output logic [31:0] imem_hrdata,
  output logic        imem_hready,
  output logic        imem_hresp,
  input  logic [31:0] dmem_haddr,
  input  logic        dmem_hwrite,
  input  logic [2:0]  dmem_hsize,
  input  logic [1:0]  dmem_htrans,
  input  logic [31:0] dmem_hwdata,
  output logic [31:0] dmem_hrdata,
  output logic        dmem_hready,
  output logic        dmem_hresp,
  output logic [31:0] qspi_haddr,
  output logic        qspi_hwrite,
  output logic [2:0]  qspi_hsize,
  output logic [1:0]  qspi_htrans,
  output logic [31:0] qspi_hwdata,
  input  logic [31:0] qspi_hrdata,
  input  logic        qspi_hready,
  output logic [1:0]  oGrant
);
  typedef enum logic [2:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE, ARB_ERR1, ARB_ERR2} arb_state_t;
  arb_state_t  r_state, w_next;
  logic [31:0] w_haddr [2];
  logic [31:0] w_hwdata [2];
  logic [2:0]  w_hsize [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [31:0] r_hrdata [2];
  logic [2:0]  r_size [2];
  logic [1:0]  w_hwrite, w_req, w_own, w_hready, w_cap, w_clr;
  logic [1:0]  r_write, r_pend_v, r_dph, r_wdv;
  logic        r_owner, r_first, w_sel, w_tie_dmem, w_issue, w_done, w_err, w_act;
  logic [31:0] r_wdog;

  assign w_haddr[0]  = imem_haddr;
  assign w_haddr[1]  = dmem_haddr;
  assign w_hwdata[0] = imem_hwdata;
  assign w_hwdata[1] = dmem_hwdata;
  assign w_hsize[0]  = imem_hsize;
  assign w_hsize[1]  = dmem_hsize;
  assign w_hwrite    = {dmem_hwrite, imem_hwrite};
  assign w_req       = {|dmem_htrans, |imem_htrans};
  assign w_own       = r_owner ? 2'b10 : 2'b01;
  assign w_act       = r_state != ARB_IDLE;
  assign w_err       = (r_state == ARB_ERR1) || (r_state == ARB_ERR2);
  // A master is ready whenever it has nothing queued; the owner also sees ready on the last error cycle.
  assign w_hready    = ~r_pend_v | ((r_state == ARB_ERR2) ? w_own : 2'b00);
  assign w_cap       = w_req & w_hready;
  assign w_clr       = (w_done || r_state == ARB_ERR2) ? w_own : 2'b00;
  assign w_sel       = &r_pend_v ? w_tie_dmem : r_pend_v[1];
  assign oGrant      = w_act ? w_own : 2'b00;
  assign qspi_htrans = w_issue ? 2'b10 : 2'b00;
  assign qspi_haddr  = w_act ? r_addr[r_owner] : '0;
  assign qspi_hwrite = w_act & r_write[r_owner];
  assign qspi_hsize  = w_act ? r_size[r_owner] : '0;
  assign qspi_hwdata = w_act ? r_wdata[r_owner] : '0;
  assign imem_hready = w_hready[0];
  assign dmem_hready = w_hready[1];
  assign imem_hresp  = w_err & ~r_owner;
  assign dmem_hresp  = w_err & r_owner;
  assign imem_hrdata = r_hrdata[0];
  assign dmem_hrdata = r_hrdata[1];

`ifdef RAIFES_QSPI_ARB_RR_EN
  logic r_last;
  assign w_tie_dmem = ~r_last;
  // Remember the last winner so the other master takes the next tie.
  always_ff @(posedge iClk or posedge iReset)
    if (iReset) r_last <= 1'b1;
    else if (r_state == ARB_IDLE && |r_pend_v) r_last <= w_sel;
`else
  assign w_tie_dmem = DPRIO;
`endif

  // Arbiter state register.
  always_ff @(posedge iClk or posedge iReset)
    if (iReset) r_state <= ARB_IDLE;
    else r_state <= w_next;

  // Next state; NONSEQ goes out only in the cycle the downstream can accept it.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ARB_IDLE:  w_next = |r_pend_v ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: begin
        w_issue = qspi_hready && r_wdv[r_owner];
        w_next  = w_issue ? ARB_WAIT : ARB_ISSUE;
      end
      ARB_WAIT: begin
        w_done = !r_first && qspi_hready;
        w_next = w_done ? ARB_DONE : (TIMEOUT_CYCLES != 0 && r_wdog == 32'd1) ? ARB_ERR1 : ARB_WAIT;
      end
      ARB_ERR1:  w_next = ARB_ERR2;
      default:   w_next = ARB_IDLE;
    endcase
  end

  // Owner selection, watchdog and the ignore-first-wait-cycle flag.
  always_ff @(posedge iClk or posedge iReset)
    if (iReset) begin
      r_owner <= 1'b0;
      r_first <= 1'b0;
      r_wdog  <= '0;
    end else begin
      if (r_state == ARB_IDLE && |r_pend_v) r_owner <= w_sel;
      if (w_issue) begin
        r_wdog  <= TIMEOUT_CYCLES;
        r_first <= 1'b1;
      end else if (r_state == ARB_WAIT) begin
        r_wdog  <= r_wdog - 32'd1;
        r_first <= 1'b0;
      end
    end

  // Per-master address-phase capture, data-phase write data and returned read data.
  always_ff @(posedge iClk or posedge iReset)
    if (iReset) begin
      r_pend_v <= '0;
      r_dph    <= '0;
      r_wdv    <= '0;
      r_write  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i]   <= '0;
        r_size[i]   <= '0;
        r_wdata[i]  <= '0;
        r_hrdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_dph[i]) begin
          r_wdata[i] <= w_hwdata[i];
          r_wdv[i]   <= 1'b1;
          r_dph[i]   <= 1'b0;
        end
        if (w_cap[i]) begin
          r_pend_v[i] <= 1'b1;
          r_addr[i]   <= w_haddr[i];
          r_write[i]  <= w_hwrite[i];
          r_size[i]   <= w_hsize[i];
          r_dph[i]    <= 1'b1;
          r_wdv[i]    <= 1'b0;
        end else if (w_clr[i]) r_pend_v[i] <= 1'b0;
        if (w_done && w_own[i] && !r_write[i]) r_hrdata[i] <= qspi_hrdata;
      end
    end
endmodule

// File: tb/tb_raifes_qspi_arbiter.sv
// tb_raifes_qspi_arbiter: directed checks of arbitration order, back-to-back capture, watchdog error and reset
module tb_raifes_qspi_arbiter;
  localparam int TO = 100;
  typedef struct packed {logic [1:0] g; logic [31:0] a; logic w; logic [2:0] s; logic [31:0] d;} iss_t;
  logic        iClk = 1'b0, iReset = 1'b0;
  logic [31:0] imem_haddr = '0, dmem_haddr = '0, imem_hwdata = '0, dmem_hwdata = '0;
  logic        imem_hwrite = 1'b0, dmem_hwrite = 1'b0;
  logic [2:0]  imem_hsize = 3'd2, dmem_hsize = 3'd2;
  logic [1:0]  imem_htrans = '0, dmem_htrans = '0;
  logic [31:0] imem_hrdata, dmem_hrdata, qspi_haddr, qspi_hwdata, qspi_hrdata;
  logic        imem_hready, dmem_hready, imem_hresp, dmem_hresp, qspi_hwrite, qspi_hready;
  logic [2:0]  qspi_hsize;
  logic [1:0]  qspi_htrans, oGrant;
  int          n_checks = 0, n_fail = 0;
  iss_t        log_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd;
  int          lat = 4, busy = 0;
  bit          hang = 1'b0;

  always #5 iClk = ~iClk;

  raifes_qspi_arbiter #(.TIMEOUT_CYCLES(TO), .DPRIO(1'b1)) dut (
    .iClk(iClk), .iReset(iReset),
    .imem_haddr(imem_haddr), .imem_hwrite(imem_hwrite), .imem_hsize(imem_hsize), .imem_htrans(imem_htrans),
    .imem_hwdata(imem_hwdata), .imem_hrdata(imem_hrdata), .imem_hready(imem_hready), .imem_hresp(imem_hresp),
    .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize), .dmem_htrans(dmem_htrans),
    .dmem_hwdata(dmem_hwdata), .dmem_hrdata(dmem_hrdata), .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
    .qspi_haddr(qspi_haddr), .qspi_hwrite(qspi_hwrite), .qspi_hsize(qspi_hsize), .qspi_htrans(qspi_htrans),
    .qspi_hwdata(qspi_hwdata), .qspi_hrdata(qspi_hrdata), .qspi_hready(qspi_hready), .oGrant(oGrant)
  );

  // QSPI model: accepts NONSEQ when idle, busy for lat cycles (forever when hang), logs every issue.
  always @(posedge iClk or posedge iReset)
    if (iReset) begin
      qspi_hready <= 1'b1;
      qspi_hrdata <= '0;
      busy        <= 0;
    end else if (busy > 0) begin
      if (!hang) begin
        busy <= busy - 1;
        if (busy == 1) begin
          qspi_hready <= 1'b1;
          qspi_hrdata <= rd;
        end
      end
    end else if (qspi_htrans == 2'b10) begin
      log_q.push_back({oGrant, qspi_haddr, qspi_hwrite, qspi_hsize, qspi_hwdata});
      if (qspi_hwrite) mem[qspi_haddr] = qspi_hwdata;
      rd          <= mem.exists(qspi_haddr) ? mem[qspi_haddr] : ~qspi_haddr;
      qspi_hready <= 1'b0;
      busy        <= lat;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic set_a(input int m, input logic [31:0] a, input logic w);
    if (m == 0) begin imem_haddr = a; imem_hwrite = w; imem_htrans = 2'b10; end
    else begin dmem_haddr = a; dmem_hwrite = w; dmem_htrans = 2'b10; end
  endtask

  task automatic idle_a(input int m, input logic [31:0] d);
    if (m == 0) begin imem_htrans = 2'b00; imem_hwdata = d; end
    else begin dmem_htrans = 2'b00; dmem_hwdata = d; end
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? imem_hready : dmem_hready;
  endfunction

  task automatic pop(output iss_t e);
    if (log_q.size() > 0) e = log_q.pop_front();
    else e = '0;
  endtask

  task automatic do_reset;
    @(negedge iClk);
    iReset = 1'b1;
    hang   = 1'b0;
    @(negedge iClk);
    iReset = 1'b0;
    log_q.delete();
    tick();
  endtask

  // Wait for master m to become ready; dly = samples between the downstream ready rise and master ready.
  task automatic wait_rdy(input int m, input string tag, output int dly);
    int rise = -1;
    bit low  = 1'b0;
    dly = -1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (rdy(m)) begin
        dly = (rise < 0) ? -1 : i - rise;
        return;
      end
      if (!qspi_hready) low = 1'b1;
      else if (low && rise < 0) rise = i;
    end
    check({tag, "_timeout"}, 32'(rdy(m)), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int d, ti, td, rr;
    bit [1:0] p, drv;
    iss_t e;
    logic [1:0] exp3 [4];
`ifdef RAIFES_QSPI_ARB_RR_EN
    exp3 = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp3 = '{2'b10, 2'b10, 2'b10, 2'b01};
`endif
    mem[32'h100] = 32'h12345678;
    mem[32'h0]   = 32'hDEADBEEF;
    mem[32'h200] = 32'h11112222;
    mem[32'h204] = 32'h33334444;
    #1 iReset = 1'b1;
    #2;
    check("rst_imem_hrdata", imem_hrdata, 32'h0);
    check("rst_dmem_hrdata", dmem_hrdata, 32'h0);
    check("rst_imem_hready", 32'(imem_hready), 32'd1);
    check("rst_dmem_hready", 32'(dmem_hready), 32'd1);
    check("rst_imem_hresp", 32'(imem_hresp), 32'd0);
    check("rst_dmem_hresp", 32'(dmem_hresp), 32'd0);
    check("rst_qspi_htrans", 32'(qspi_htrans), 32'd0);
    check("rst_qspi_haddr", qspi_haddr, 32'h0);
    check("rst_qspi_hwdata", qspi_hwdata, 32'h0);
    check("rst_grant", 32'(oGrant), 32'd0);
    @(negedge iClk);
    iReset = 1'b0;
    repeat (2) tick();

    // single imem read, 70-cycle downstream latency
    lat = 70;
    set_a(0, 32'h100, 1'b0);
    tick();
    idle_a(0, 32'h0);
    check("t1_stall", 32'(imem_hready), 32'd0);
    wait_rdy(0, "t1", d);
    check("t1_rdata", imem_hrdata, 32'h12345678);
    check("t1_resp", 32'(imem_hresp), 32'd0);
    check("t1_delay", d, 32'd1);
    check("t1_nissue", log_q.size(), 32'd1);
    pop(e);
    check("t1_grant", 32'(e.g), 32'd1);
    check("t1_addr", e.a, 32'h100);

    // same-cycle imem read and dmem write: dmem first
    lat = 5;
    set_a(0, 32'h0, 1'b0);
    set_a(1, 32'h40, 1'b1);
    tick();
    idle_a(0, 32'h0);
    idle_a(1, 32'hCAFEBABE);
    wait_rdy(1, "t2d", d);
    check("t2_d_resp", 32'(dmem_hresp), 32'd0);
    check("t2_i_held", 32'(imem_hready), 32'd0);
    wait_rdy(0, "t2i", d);
    check("t2_i_rdata", imem_hrdata, 32'hDEADBEEF);
    check("t2_i_resp", 32'(imem_hresp), 32'd0);
    check("t2_nissue", log_q.size(), 32'd2);
    pop(e);
    check("t2_1st_grant", 32'(e.g), 32'd2);
    check("t2_1st_addr", e.a, 32'h40);
    check("t2_1st_write", 32'(e.w), 32'd1);
    check("t2_1st_size", 32'(e.s), 32'd2);
    check("t2_1st_wdata", e.d, 32'hCAFEBABE);
    pop(e);
    check("t2_2nd_grant", 32'(e.g), 32'd1);
    check("t2_2nd_addr", e.a, 32'h0);
    check("t2_2nd_write", 32'(e.w), 32'd0);

    // three tie rounds with the winner re-requesting in its done cycle
    do_reset();
    lat = 3;
    p   = 2'b11;
    drv = 2'b00;
    rr  = 2;
    set_a(0, 32'h10, 1'b0);
    set_a(1, 32'h20, 1'b0);
    tick();
    idle_a(0, 32'h0);
    idle_a(1, 32'h0);
    for (int i = 0; i < 2000 && p != 2'b00; i++) begin
      tick();
      for (int m = 0; m < 2; m++) if (drv[m]) begin idle_a(m, 32'h0); drv[m] = 1'b0; end
      for (int m = 0; m < 2; m++) if (p[m] && rdy(m)) begin
        p[m] = 1'b0;
        if (rr > 0) begin
          set_a(m, 32'h30 + 32'(m) * 4, 1'b0);
          p[m] = 1'b1;
          drv[m] = 1'b1;
          rr--;
        end
      end
    end
    check("t3_drained", 32'(p), 32'd0);
    check("t3_nissue", log_q.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      pop(e);
      check($sformatf("t3_grant%0d", k), 32'(e.g), 32'(exp3[k]));
    end

    // back-to-back dmem reads captured in the done cycle
    lat = 6;
    set_a(1, 32'h200, 1'b0);
    tick();
    idle_a(1, 32'h0);
    wait_rdy(1, "t6a", d);
    check("t6_rd0", dmem_hrdata, 32'h11112222);
    set_a(1, 32'h204, 1'b0);
    tick();
    idle_a(1, 32'h0);
    check("t6_captured", 32'(dmem_hready), 32'd0);
    wait_rdy(1, "t6b", d);
    check("t6_rd1", dmem_hrdata, 32'h33334444);
    check("t6_nissue", log_q.size(), 32'd2);
    pop(e);
    check("t6_addr0", e.a, 32'h200);
    pop(e);
    check("t6_addr1", e.a, 32'h204);

    // hung downstream: watchdog error on dmem
    hang = 1'b1;
    set_a(1, 32'h300, 1'b0);
    tick();
    idle_a(1, 32'h0);
    ti = -1;
    td = -1;
    for (int i = 0; i < 500 && td < 0; i++) begin
      if (ti < 0 && qspi_htrans == 2'b10) ti = i;
      if (dmem_hresp) td = i;
      else tick();
    end
    check("t4_err_cycle", td - ti, TO + 1);
    check("t4_e1_ready", 32'(dmem_hready), 32'd0);
    check("t4_e1_resp", 32'(dmem_hresp), 32'd1);
    check("t4_other_ready", 32'(imem_hready), 32'd1);
    check("t4_other_resp", 32'(imem_hresp), 32'd0);
    tick();
    check("t4_e2_ready", 32'(dmem_hready), 32'd1);
    check("t4_e2_resp", 32'(dmem_hresp), 32'd1);
    tick();
    check("t4_after_resp", 32'(dmem_hresp), 32'd0);
    check("t4_after_ready", 32'(dmem_hready), 32'd1);
    check("t4_after_grant", 32'(oGrant), 32'd0);
    do_reset();

    // reset while waiting on the downstream
    lat = 70;
    set_a(0, 32'h100, 1'b0);
    tick();
    idle_a(0, 32'h0);
    for (int i = 0; i < 50 && qspi_htrans != 2'b10; i++) tick();
    repeat (5) tick();
    check("t5_pre_ready", 32'(imem_hready), 32'd0);
    check("t5_pre_grant", 32'(oGrant), 32'd1);
    iReset = 1'b1;
    #1;
    check("t5_rst_ready", 32'(imem_hready), 32'd1);
    check("t5_rst_htrans", 32'(qspi_htrans), 32'd0);
    check("t5_rst_grant", 32'(oGrant), 32'd0);
    @(negedge iClk);
    iReset = 1'b0;
    log_q.delete();
    tick();
    lat = 4;
    set_a(0, 32'h204, 1'b0);
    tick();
    idle_a(0, 32'h0);
    wait_rdy(0, "t5", d);
    check("t5_rdata", imem_hrdata, 32'h33334444);
    check("t5_resp", 32'(imem_hresp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
